// File: rtl/proc_vec_pkg.sv
// Shared definitions for the vector processor front end.
// Widths, HALT opcode and the fetch FSM state encoding.
package proc_vec_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 14;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fifo_fetch.sv
// Two-entry prefetch queue of {pc, instruction}.
// Slot 0 is always the head; flush wins over push.
module fifo_fetch
    import proc_vec_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [1:0]         count,
    output logic               empty,
    output logic               full
);

    logic [ADDR_W-1:0]  pc0, pc1;
    logic [INSTR_W-1:0] ins0, ins1;
    logic [1:0]         cnt;
    logic               do_pop, do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    assign head_pc    = pc0;
    assign head_instr = ins0;
    assign count      = cnt;
    assign empty      = (cnt == 2'd0);
    assign full       = (cnt == 2'd2);

    // Shift-style storage so the head always sits in slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc0  <= '0;
            pc1  <= '0;
            ins0 <= '0;
            ins1 <= '0;
            cnt  <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        pc0  <= push_pc;
                        ins0 <= push_instr;
                    end else begin
                        pc1  <= push_pc;
                        ins1 <= push_instr;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    pc0  <= pc1;
                    ins0 <= ins1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        pc0  <= push_pc;
                        ins0 <= push_instr;
                    end else begin
                        pc0  <= pc1;
                        ins0 <= ins1;
                        pc1  <= push_pc;
                        ins1 <= push_instr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/etapa_fetch.sv
// Instruction fetch stage: PC, imem handshake, 2-entry prefetch.
// Optional FETCH_HALT_EN stops fetching after a HALT opcode.
module etapa_fetch
    import proc_vec_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid_out
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;
    logic              ack_ok, flush, push, pop;
    logic              fifo_empty, fifo_full;
    logic [1:0]        fifo_count, occ_next;

    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;
    assign valid_out = !fifo_empty;

    // Acks are only meaningful while a request is on the bus
    assign ack_ok = imem_req && imem_ack;
`ifdef FETCH_HALT_EN
    assign flush = branch_taken && (state_q != HALT);
`else
    assign flush = branch_taken;
`endif
    assign pop      = valid_out && !stall && !flush;
    assign push     = ack_ok && !discard_q && !flush;
    assign occ_next = flush ? 2'd0
                    : fifo_count + {1'b0, push} - {1'b0, pop};

    fifo_fetch #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_pc   (addr_q),
        .push_instr(imem_data),
        .head_pc   (pc_out),
        .head_instr(instruction_out),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Next state, next PC and next request address
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        if (ack_ok) discard_d = 1'b0;
        if (push) fetch_pc_d = addr_q + 1'b1;
        if (flush) fetch_pc_d = branch_target;
        if (flush && imem_req && !imem_ack) discard_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                addr_d  = fetch_pc_d;
            end
            REQ: begin
                if (ack_ok) begin
                    if (occ_next == 2'd2) begin
                        state_d = FULL;
                    end else begin
                        addr_d = fetch_pc_d;
                    end
                end
            end
            FULL: begin
                if (!fifo_full || pop || flush) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_d;
                end
            end
            default: ;
        endcase
`ifdef FETCH_HALT_EN
        if (push && imem_data[INSTR_W-1 -: 4] == HALT_OPCODE)
            state_d = HALT;
`endif
    end

    // Fetch control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_etapa_fetch.sv
// Self-checking bench for etapa_fetch.
// Scoreboard of expected {pc, instr} plus directed corner sequences.
module tb_etapa_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [13:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [13:0] instruction_out;
    logic [7:0]  pc_out;
    logic        valid_out;

    etapa_fetch #(
        .ADDR_W  (8),
        .INSTR_W (14),
        .RESET_PC(8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [13:0] instr;
    } exp_t;

    typedef struct {
        int         lat;
        logic [7:0] target;
        logic [7:0] held_addr;
        logic [7:0] pc0;
        logic [7:0] pc1;
        logic [7:0] pc2;
    } br_vec_t;

    exp_t    sbq[$];
    br_vec_t vecs[4];

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    int n_acks   = 0;
    int mem_lat  = 0;
    logic mon_en    = 1'b0;
    logic force_ack = 1'b0;
    logic halt_word = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] mem_word(input logic [7:0] a);
        if (halt_word && a == 8'h02) return 14'h3C00;
        return {6'b0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sbq.push_back(e);
    endtask

    task automatic do_reset(input int lat);
        mon_en        = 1'b0;
        sbq.delete();
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        force_ack     = 1'b0;
        halt_word     = 1'b0;
        mem_lat       = lat;
        tick;
        tick;
    endtask

    // Instruction memory: acks after mem_lat waiting cycles, data = addr
    initial begin
        int wcnt;
        wcnt      = 0;
        imem_ack  = 1'b0;
        imem_data = 14'h0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                imem_ack  = 1'b1;
                imem_data = 14'h2AAA;
                @(posedge clk);
                #1;
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (wcnt >= mem_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = mem_word(imem_addr);
                    wcnt      = 0;
                    n_acks++;
                end else begin
                    imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Output monitor: compares each consumed head entry with the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && valid_out && !stall && !branch_taken) begin
                n_pops++;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra: got pc 0x%0h expected none",
                             pc_out);
                end else begin
                    e = sbq.pop_front();
                    check("sb_pc", pc_out, e.pc);
                    check("sb_instr", instruction_out, e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0;
        int a0;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;

        vecs[0] = '{1, 8'h40, 8'h05, 8'h40, 8'h41, 8'h42};
        vecs[1] = '{0, 8'h40, 8'h40, 8'h40, 8'h41, 8'h42};
        vecs[2] = '{2, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'h01};
        vecs[3] = '{3, 8'h10, 8'h05, 8'h10, 8'h11, 8'h12};

        // Reset state and zero-wait streaming with PC wrap
        do_reset(0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", valid_out, 0);
        check("rst_instr", instruction_out, 0);
        check("rst_pc", pc_out, 0);
        rst = 1'b0;
        for (int p = 0; p < 300; p++) push_exp(p[7:0]);
        mon_en = 1'b1;
        tick;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        check("first_valid", valid_out, 0);
        tick;
        tick;
        check("valid_by_edge3", valid_out, 1);
        k = 0;
        while (imem_addr != 8'hFF && k < 300) begin tick; k++; end
        if (k >= 300) timeout("wait_addr_ff");
        tick;
        check("addr_wrap", imem_addr, 0);
        p0 = n_pops;
        repeat (20) tick;
        check("throughput", n_pops - p0, 20);

        // Stall at pc 3: hold, stop requesting when full, no bubble after
        do_reset(0);
        rst = 1'b0;
        for (int p = 0; p < 21; p++) push_exp(p[7:0]);
        mon_en = 1'b1;
        k = 0;
        while (!(valid_out && pc_out == 8'h03) && k < 20) begin tick; k++; end
        if (k >= 20) timeout("wait_pc3");
        stall = 1'b1;
        repeat (5) begin
            tick;
            check("stall_pc", pc_out, 3);
            check("stall_instr", instruction_out, 3);
            check("stall_valid", valid_out, 1);
            check("stall_req", imem_req, 0);
        end
        stall = 1'b0;
        tick;
        check("rel_pc4", pc_out, 4);
        check("rel_valid4", valid_out, 1);
        tick;
        check("rel_pc5", pc_out, 5);
        check("rel_valid5", valid_out, 1);
        mon_en = 1'b0;

        // Slow memory: address held until ack, one word per ack
        do_reset(3);
        rst = 1'b0;
        for (int p = 0; p < 16; p++) push_exp(p[7:0]);
        mon_en = 1'b1;
        a0 = n_acks;
        p0 = n_pops;
        repeat (4) begin
            tick;
            check("slow_req", imem_req, 1);
            check("slow_addr", imem_addr, 0);
            check("slow_valid", valid_out, 0);
        end
        tick;
        check("slow_first_valid", valid_out, 1);
        check("slow_first_pc", pc_out, 0);
        repeat (20) tick;
        k = 0;
        while (valid_out && k < 10) begin tick; k++; end
        if (k >= 10) timeout("slow_drain");
        check("slow_one_per_ack", n_pops - p0, n_acks - a0);
        mon_en = 1'b0;

        // Branch redirect table, request to 0x05 in flight
        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].lat);
            rst = 1'b0;
            k = 0;
            while (!(imem_req && imem_addr == 8'h05) && k < 60) begin
                tick;
                k++;
            end
            if (k >= 60) timeout("br_wait_05");
            branch_taken  = 1'b1;
            branch_target = vecs[i].target;
            push_exp(vecs[i].pc0);
            push_exp(vecs[i].pc1);
            push_exp(vecs[i].pc2);
            tick;
            branch_taken = 1'b0;
            check("br_flush_valid", valid_out, 0);
            check("br_held_addr", imem_addr, vecs[i].held_addr);
            mon_en = 1'b1;
            k = 0;
            while (imem_addr == 8'h05 && k < 10) begin tick; k++; end
            if (k >= 10) timeout("br_wait_target");
            check("br_next_addr", imem_addr, vecs[i].target);
            k = 0;
            while (sbq.size() != 0 && k < 40) begin tick; k++; end
            if (k >= 40) timeout("br_outputs");
            mon_en = 1'b0;
        end

        // Reset mid-request with a buffered entry, then a stray ack
        do_reset(6);
        rst   = 1'b0;
        stall = 1'b1;
        k = 0;
        while (!(valid_out && imem_req) && k < 30) begin tick; k++; end
        if (k >= 30) timeout("rst_mid_setup");
        #3;
        rst = 1'b1;
        #1;
        check("rmid_req", imem_req, 0);
        check("rmid_addr", imem_addr, 0);
        check("rmid_valid", valid_out, 0);
        check("rmid_instr", instruction_out, 0);
        check("rmid_pc", pc_out, 0);
        tick;
        rst       = 1'b0;
        stall     = 1'b0;
        mem_lat   = 0;
        force_ack = 1'b1;
        for (int p = 0; p < 4; p++) push_exp(p[7:0]);
        mon_en = 1'b1;
        tick;
        force_ack = 1'b0;
        check("late_ack_valid", valid_out, 0);
        check("late_ack_req", imem_req, 1);
        check("late_ack_addr", imem_addr, 0);
        k = 0;
        while (sbq.size() != 0 && k < 20) begin tick; k++; end
        if (k >= 20) timeout("after_rst_outputs");
        mon_en = 1'b0;

        // HALT opcode at pc 2
        do_reset(0);
        halt_word = 1'b1;
        rst = 1'b0;
        push_exp(8'h00);
        push_exp(8'h01);
        push_exp(8'h02);
`ifndef FETCH_HALT_EN
        push_exp(8'h03);
        push_exp(8'h04);
`endif
        mon_en = 1'b1;
        k = 0;
        while (sbq.size() != 0 && k < 20) begin tick; k++; end
        if (k >= 20) timeout("halt_outputs");
        mon_en = 1'b0;
        check("halt_sb_empty", sbq.size(), 0);
`ifdef FETCH_HALT_EN
        repeat (3) tick;
        check("halt_req", imem_req, 0);
        check("halt_valid", valid_out, 0);
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        tick;
        branch_taken = 1'b0;
        repeat (2) tick;
        check("halt_br_req", imem_req, 0);
        check("halt_br_valid", valid_out, 0);
`else
        check("nohalt_req", imem_req, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
